// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_right_seq
// Brief    : Iterative right shifter that moves one bit per clock, with
//            logical (zero) or arithmetic (sign) fill and a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5   // 2**SHAMT_W must be >= WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   in_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   out_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [SHAMT_W-1:0] C_CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] C_CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               arith_q, arith_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One-bit shift of the working register. The fill bit is the current MSB
  // when arithmetic, so the sign captured at load keeps propagating.
  logic [WIDTH-1:0]   sr_shifted_w;
  assign sr_shifted_w = {arith_q & sr_q[WIDTH-1], sr_q[WIDTH-1:1]};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sr_d    = in_i;
          cnt_d   = shamt_i;
          arith_d = arith_i;
          if (shamt_i == C_CNT_ZERO) begin
            // Zero shift: result is the operand itself, skip SHIFT entirely.
            state_d = S_DONE;
            out_d   = in_i;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sr_d  = sr_shifted_w;
        cnt_d = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          // Last shift: publish the result on entry to DONE.
          state_d = S_DONE;
          out_d   = sr_shifted_w;
        end
      end
      S_DONE: begin
        // Starts arriving here are dropped; only IDLE accepts a request.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the upcoming state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any shift in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_right_seq
// Brief    : Scoreboard bench for shift_right_seq: directed cases plus
//            random back-to-back requests checked against >> / >>>.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_right_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               start_i;
  logic [WIDTH-1:0]   in_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               arith_i;
  logic               busy_o;
  logic               done_o;
  logic [WIDTH-1:0]   out_o;

  shift_right_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_i),
    .in_i    (in_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .out_o   (out_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] exp_out;
    int               exp_edge;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain shift operators on the captured operand.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                 input int s, input logic ar);
    if (ar) return WIDTH'($signed(a) >>> s);
    return a >> s;
  endfunction

  // Monitor: compares every Done against the oldest pending expectation and
  // checks that Out is held and Busy drops right after Done.
  logic [WIDTH-1:0] last_out  = '0;
  logic             prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      last_out  = '0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_low_after_done", {31'b0, busy_o}, 32'd0);
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", out_o, e.exp_out);
          chk("done_latency_edge", WIDTH'(edge_cnt), WIDTH'(e.exp_edge));
          last_out = e.exp_out;
        end
      end else begin
        chk("out_held", out_o, last_out);
      end
      prev_done = done_o;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_o) return;
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input int s, input logic ar);
    wait_idle();
    in_i    = a;
    shamt_i = SHAMT_W'(s);
    arith_i = ar;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    // Scramble inputs: the operation in flight must not see them.
    in_i    = $urandom;
    shamt_i = SHAMT_W'($urandom);
    arith_i = 1'($urandom);
    sb.push_back('{exp_out: ref_shift(a, s, ar), exp_edge: edge_cnt + s});
    chk("busy_after_start", {31'b0, busy_o}, 32'd1);
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] a, input int s);
    in_i    = a;
    shamt_i = SHAMT_W'(s);
    arith_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a;
    int               s;
    logic             ar;
    bit               seen;

    start_i = 1'b0;
    in_i    = '0;
    shamt_i = '0;
    arith_i = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_done", {31'b0, done_o}, 32'd0);
    chk("reset_out", out_o, 32'd0);
    #2 rst_n = 1'b1;

    // Directed cases from the plan.
    issue(32'h8000_0000, 4,  1'b0);
    issue(32'h8000_0000, 4,  1'b1);
    issue(32'h8000_0000, 31, 1'b1);
    issue(32'h7FFF_FFFF, 31, 1'b1);
    issue(32'h0000_0400, 2,  1'b0);
    issue(32'h1234_5678, 0,  1'b0);

    // Starts during SHIFT and in the Done cycle must be ignored.
    issue(32'hFFFF_0000, 8, 1'b0);
    @(negedge clk);
    pulse_start(32'h1, 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done_o;
    end
    if (!seen) chk("busy_test_done_timeout", 32'd1, 32'd0);
    pulse_start(32'h1, 1);

    // Asynchronous reset in the middle of a long shift.
    issue(32'hDEAD_BEEF, 20, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("async_rst_done", {31'b0, done_o}, 32'd0);
    chk("async_rst_out", out_o, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(32'hA000_0000, 1, 1'b1);

    // Random back-to-back requests.
    for (int n = 0; n < 50; n++) begin
      a  = $urandom;
      s  = int'($urandom_range(0, WIDTH - 1));
      ar = 1'($urandom);
      issue(a, s, ar);
    end

    // Drain outstanding expectations.
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", WIDTH'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
